systolic_array_os: RTL and testbench

Parametrised output-stationary systolic matrix-multiply engine. It is the next generation of the team's PE-grid array and adds:
- separate rectangular row/column counts;
- a wide accumulator;
- on-chip input skewing;
- a control FSM that sequences load, flush and result drain over valid/ready handshakes.

It sits between the input/weight buffers (producers of A-column and B-row vectors) and the output buffer (consumer of C rows). Each operation computes C[ROWS×COLS] = A[ROWS×K] · B[K×COLS].

---
 rtl/systolic_array_os.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_systolic_array_os.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_os.sv
// -----------------------------------------------------------------------------
// systolic_array_os
//
// Output-stationary systolic matrix-multiply engine computing
// C[ROWS x COLS] = A[ROWS x K] * B[K x COLS] with signed DATA_W operands and
// ACC_W-bit accumulators held inside each processing element (PE).
//
// A control FSM (IDLE -> LOAD -> FLUSH -> DRAIN -> IDLE) does the following:
//   - accepts one operand beat per a_valid/a_ready handshake;
//   - skews the operands on chip;
//   - flushes the wavefront through the grid;
//   - presents one result row per out_valid/out_ready handshake.
//
// Optional feature macro: SA_SATURATE_EN
//   defined   -> every accumulate clamps to the signed ACC_W range
//   undefined -> accumulation wraps modulo 2^ACC_W
//
// Ports:
//   clock      : single clock, rising edge
//   reset      : asynchronous, active-high; clears all state
//   start      : begin an operation (only honoured in IDLE)
//   k_len      : reduction length, sampled with start
//   a_valid    : operand beat valid
//   a_ready    : operand beat accepted when a_valid && a_ready (LOAD only)
//   a_data     : ROWS x DATA_W, slice i = A[i][k] for beat k
//   b_data     : COLS x DATA_W, slice j = B[k][j] for beat k
//   out_valid  : result row valid (DRAIN)
//   out_ready  : result consumer ready
//   out_row    : index of the presented row
//   out_data   : COLS x ACC_W, slice j = C[out_row][j]
//   busy       : FSM not in IDLE
//   done       : one-cycle pulse after the last row handshake
// -----------------------------------------------------------------------------
module systolic_array_os #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int K_MAX  = 256
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [$clog2(K_MAX+1)-1:0]            k_len,
  input  logic                                  a_valid,
  output logic                                  a_ready,
  input  logic [ROWS*DATA_W-1:0]                a_data,
  input  logic [COLS*DATA_W-1:0]                b_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
  output logic [COLS*ACC_W-1:0]                 out_data,
  output logic                                  busy,
  output logic                                  done
);

  localparam int KW      = $clog2(K_MAX + 1);
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FLUSH_N = ROWS + COLS - 2;
  localparam int FW      = $clog2(ROWS + COLS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  logic [1:0]    state_reg, state_next;
  logic [KW-1:0] k_len_reg, k_len_next;
  logic [KW-1:0] beat_cnt_reg, beat_cnt_next;
  logic [FW-1:0] flush_cnt_reg, flush_cnt_next;
  logic [RW-1:0] out_row_reg, out_row_next;
  logic          done_reg, done_next;

  always_comb begin
    state_next     = state_reg;
    k_len_next     = k_len_reg;
    beat_cnt_next  = beat_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    out_row_next   = out_row_reg;
    done_next      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          k_len_next     = k_len;
          beat_cnt_next  = '0;
          flush_cnt_next = '0;
          out_row_next   = '0;
          // A zero-length reduction has nothing to load: results are the
          // freshly cleared accumulators.
          state_next     = (k_len == '0) ? ST_DRAIN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (a_valid) begin
          if (beat_cnt_reg == k_len_reg - KW'(1)) begin
            beat_cnt_next = '0;
            // A 1x1 grid has no wavefront to flush.
            state_next    = (FLUSH_N == 0) ? ST_DRAIN : ST_FLUSH;
          end else begin
            beat_cnt_next = beat_cnt_reg + KW'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_reg == FW'(FLUSH_N - 1)) begin
          flush_cnt_next = '0;
          state_next     = ST_DRAIN;
        end else begin
          flush_cnt_next = flush_cnt_reg + FW'(1);
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (out_row_reg == RW'(ROWS - 1)) begin
            out_row_next = '0;
            done_next    = 1'b1;
            state_next   = ST_IDLE;
          end else begin
            out_row_next = out_row_reg + RW'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      k_len_reg     <= '0;
      beat_cnt_reg  <= '0;
      flush_cnt_reg <= '0;
      out_row_reg   <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      k_len_reg     <= k_len_next;
      beat_cnt_reg  <= beat_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
      out_row_reg   <= out_row_next;
      done_reg      <= done_next;
    end
  end

  assign a_ready   = (state_reg == ST_LOAD);
  assign out_valid = (state_reg == ST_DRAIN);
  assign busy      = (state_reg != ST_IDLE);
  assign done      = done_reg;
  assign out_row   = out_row_reg;

  // ---------------------------------------------------------------------------
  // Array sequencing
  // ---------------------------------------------------------------------------
  // The whole array (skew, pass-through and accumulators) moves one step per
  // accepted beat in LOAD and unconditionally in FLUSH; otherwise it holds.
  logic clear_arr;
  logic advance;
  logic [ROWS*DATA_W-1:0] a_inj;
  logic [COLS*DATA_W-1:0] b_inj;

  assign clear_arr = (state_reg == ST_IDLE) && start;
  assign advance   = ((state_reg == ST_LOAD) && a_valid) || (state_reg == ST_FLUSH);
  // Zeros are injected during FLUSH so trailing steps add zero products.
  assign a_inj     = (state_reg == ST_LOAD) ? a_data : '0;
  assign b_inj     = (state_reg == ST_LOAD) ? b_data : '0;

  // a_link slot (i,j) is the A operand seen by PE(i,j); b_link likewise for B.
  // Column-0 / row-0 slots come from the skew stage, the rest from the
  // neighbouring PE's pass-through register.
  logic [ROWS*COLS*DATA_W-1:0] a_link;
  logic [ROWS*COLS*DATA_W-1:0] b_link;
  logic [ROWS*COLS*ACC_W-1:0]  acc_flat;

  genvar gi, gj;

  // Row i of A is delayed i advance steps.
  for (gi = 0; gi < ROWS; gi++) begin : g_a_skew
    if (gi == 0) begin : g_direct
      assign a_link[0 +: DATA_W] = a_inj[0 +: DATA_W];
    end else begin : g_delay
      logic [DATA_W-1:0] dly_reg [gi];
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int t = 0; t < gi; t++) dly_reg[t] <= '0;
        end else if (clear_arr) begin
          for (int t = 0; t < gi; t++) dly_reg[t] <= '0;
        end else if (advance) begin
          dly_reg[0] <= a_inj[gi*DATA_W +: DATA_W];
          for (int t = 1; t < gi; t++) dly_reg[t] <= dly_reg[t-1];
        end
      end
      assign a_link[(gi*COLS)*DATA_W +: DATA_W] = dly_reg[gi-1];
    end
  end

  // Column j of B is delayed j advance steps.
  for (gj = 0; gj < COLS; gj++) begin : g_b_skew
    if (gj == 0) begin : g_direct
      assign b_link[0 +: DATA_W] = b_inj[0 +: DATA_W];
    end else begin : g_delay
      logic [DATA_W-1:0] dly_reg [gj];
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int t = 0; t < gj; t++) dly_reg[t] <= '0;
        end else if (clear_arr) begin
          for (int t = 0; t < gj; t++) dly_reg[t] <= '0;
        end else if (advance) begin
          dly_reg[0] <= b_inj[gj*DATA_W +: DATA_W];
          for (int t = 1; t < gj; t++) dly_reg[t] <= dly_reg[t-1];
        end
      end
      assign b_link[gj*DATA_W +: DATA_W] = dly_reg[gj-1];
    end
  end

  // ---------------------------------------------------------------------------
  // PE grid: PE(i,j) sees pair k at step k+i+j.
  // ---------------------------------------------------------------------------
  for (gi = 0; gi < ROWS; gi++) begin : g_row
    for (gj = 0; gj < COLS; gj++) begin : g_col
      logic signed [DATA_W-1:0]   a_in, b_in;
      logic signed [2*DATA_W-1:0] prod;
      logic signed [ACC_W-1:0]    prod_ext, acc_reg, acc_next;

      assign a_in     = a_link[(gi*COLS+gj)*DATA_W +: DATA_W];
      assign b_in     = b_link[(gi*COLS+gj)*DATA_W +: DATA_W];
      assign prod     = a_in * b_in;
      assign prod_ext = ACC_W'(prod);

`ifdef SA_SATURATE_EN
      // One guard bit exposes signed overflow; clamp towards its direction.
      localparam int SW = ACC_W + 1;
      logic signed [ACC_W:0] sum_wide;
      assign sum_wide = SW'(acc_reg) + SW'(prod_ext);
      always_comb begin
        acc_next = sum_wide[ACC_W-1:0];
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
          acc_next = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
        end
      end
`else
      assign acc_next = acc_reg + prod_ext;
`endif

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          acc_reg <= '0;
        end else if (clear_arr) begin
          acc_reg <= '0;
        end else if (advance) begin
          acc_reg <= acc_next;
        end
      end
      assign acc_flat[(gi*COLS+gj)*ACC_W +: ACC_W] = acc_reg;

      // Rightmost column has no eastern neighbour, so no A pass-through.
      if (gj < COLS - 1) begin : g_a_fwd
        logic [DATA_W-1:0] a_reg;
        always_ff @(posedge clock or posedge reset) begin
          if (reset) begin
            a_reg <= '0;
          end else if (clear_arr) begin
            a_reg <= '0;
          end else if (advance) begin
            a_reg <= a_in;
          end
        end
        assign a_link[(gi*COLS+gj+1)*DATA_W +: DATA_W] = a_reg;
      end

      // Bottom row has no southern neighbour, so no B pass-through.
      if (gi < ROWS - 1) begin : g_b_fwd
        logic [DATA_W-1:0] b_reg;
        always_ff @(posedge clock or posedge reset) begin
          if (reset) begin
            b_reg <= '0;
          end else if (clear_arr) begin
            b_reg <= '0;
          end else if (advance) begin
            b_reg <= b_in;
          end
        end
        assign b_link[((gi+1)*COLS+gj)*DATA_W +: DATA_W] = b_reg;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result row select
  // ---------------------------------------------------------------------------
  always_comb begin
    out_data = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (out_row_reg == RW'(r)) out_data = acc_flat[r*COLS*ACC_W +: COLS*ACC_W];
    end
  end

endmodule

// File: tb/tb_systolic_array_os.sv
// -----------------------------------------------------------------------------
// tb_systolic_array_os
//
// Drives two engines from the same stimulus (ACC_W=32 and ACC_W=16) and checks
// every presented row against a matrix-product reference model. Covers reset
// state, handshake stalls, latency, k_len=0, start-during-DRAIN, mid-LOAD
// reset and randomized operations.
// -----------------------------------------------------------------------------
module tb_systolic_array_os;
  localparam int DATA_W = 8;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int K_MAX  = 256;
  localparam int KW     = $clog2(K_MAX + 1);
  localparam int RW     = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic a_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic [ROWS*DATA_W-1:0] a_data = '0;
  logic [COLS*DATA_W-1:0] b_data = '0;

  logic a_ready, out_valid, busy, done;
  logic [RW-1:0] out_row;
  logic [COLS*32-1:0] out_data;
  logic a_ready16, out_valid16, busy16, done16;
  logic [RW-1:0] out_row16;
  logic [COLS*16-1:0] out_data16;

  int vectors = 0;
  int miscompares = 0;

  int     mat_a [ROWS][K_MAX];
  int     mat_b [K_MAX][COLS];
  longint exp32 [ROWS][COLS];
  longint exp16 [ROWS][COLS];

  always #5 clock = ~clock;

  systolic_array_os #(.DATA_W(DATA_W), .ACC_W(32), .ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX)) u_dut (
    .clock(clock), .reset(reset), .start(start), .k_len(k_len),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_data(out_data),
    .busy(busy), .done(done)
  );

  systolic_array_os #(.DATA_W(DATA_W), .ACC_W(16), .ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX)) u_dut16 (
    .clock(clock), .reset(reset), .start(start), .k_len(k_len),
    .a_valid(a_valid), .a_ready(a_ready16), .a_data(a_data), .b_data(b_data),
    .out_valid(out_valid16), .out_ready(out_ready), .out_row(out_row16), .out_data(out_data16),
    .busy(busy16), .done(done16)
  );

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One accumulate step of a w-bit signed accumulator.
  function automatic longint acc_step(input longint acc, input longint p, input int w);
    longint s;
    longint hi;
    longint lo;
    s  = acc + p;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
`ifdef SA_SATURATE_EN
    if (s > hi) s = hi;
    if (s < lo) s = lo;
`else
    if (w == 16) s = longint'(shortint'(s));
    else         s = longint'(int'(s));
`endif
    return s;
  endfunction

  task automatic compute_model(input int k);
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        longint s32 = 0;
        longint s16 = 0;
        for (int kk = 0; kk < k; kk++) begin
          longint p = longint'(mat_a[i][kk]) * longint'(mat_b[kk][j]);
          s32 = acc_step(s32, p, 32);
          s16 = acc_step(s16, p, 16);
        end
        exp32[i][j] = s32;
        exp16[i][j] = s16;
      end
    end
  endtask

  task automatic fill_identity();
    for (int kk = 0; kk < 4; kk++) begin
      for (int i = 0; i < ROWS; i++) mat_a[i][kk] = (i == kk) ? 1 : 0;
      for (int j = 0; j < COLS; j++) mat_b[kk][j] = 4 * kk + j;
    end
  endtask

  task automatic fill_const(input int k, input int av, input int bv);
    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < ROWS; i++) mat_a[i][kk] = av;
      for (int j = 0; j < COLS; j++) mat_b[kk][j] = bv;
    end
  endtask

  task automatic fill_random(input int k);
    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < ROWS; i++) mat_a[i][kk] = $urandom_range(0, 255) - 128;
      for (int j = 0; j < COLS; j++) mat_b[kk][j] = $urandom_range(0, 255) - 128;
    end
  endtask

  task automatic drive_beat(input int kk, input bit valid);
    for (int i = 0; i < ROWS; i++)
      a_data[i*DATA_W +: DATA_W] = valid ? 8'(mat_a[i][kk]) : 8'($urandom);
    for (int j = 0; j < COLS; j++)
      b_data[j*DATA_W +: DATA_W] = valid ? 8'(mat_b[kk][j]) : 8'($urandom);
  endtask

  task automatic check_row(input string name, input int r);
    check($sformatf("%s:valid r%0d", name, r), out_valid, 1);
    check($sformatf("%s:valid16 r%0d", name, r), out_valid16, 1);
    check($sformatf("%s:row r%0d", name, r), out_row, r);
    check($sformatf("%s:row16 r%0d", name, r), out_row16, r);
    for (int j = 0; j < COLS; j++) begin
      check($sformatf("%s:c32 r%0d c%0d", name, r, j), $signed(out_data[j*32 +: 32]), exp32[r][j]);
      check($sformatf("%s:c16 r%0d c%0d", name, r, j), $signed(out_data16[j*16 +: 16]), exp16[r][j]);
    end
  endtask

  // in_mode: 0 = a_valid always high, 1 = 1,0,0 pattern, 2 = random.
  task automatic run_op(input int k, input int in_mode, input bit out_stall,
                        input bit start_in_drain, input string name);
    int beat;
    int cyc;
    int wait_n;
    int stall;
    compute_model(k);
    k_len = KW'(k);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check({name, ":busy"}, busy, 1);
    check({name, ":busy16"}, busy16, 1);
    check({name, ":done_low"}, done, 0);
    beat = 0;
    cyc  = 0;
    while (beat < k) begin
      case (in_mode)
        0:       a_valid = 1'b1;
        1:       a_valid = (cyc % 3 == 0);
        default: a_valid = 1'($urandom_range(0, 1));
      endcase
      drive_beat(beat, a_valid);
      check($sformatf("%s:a_ready c%0d", name, cyc), a_ready, 1);
      check($sformatf("%s:a_ready16 c%0d", name, cyc), a_ready16, 1);
      @(negedge clock);
      if (a_valid) beat++;
      cyc++;
    end
    a_valid = 1'b0;
    wait_n = 0;
    while (!out_valid && wait_n < 40) begin
      @(negedge clock);
      wait_n++;
    end
    check({name, ":latency"}, wait_n, (k > 0) ? ROWS + COLS - 2 : 0);
    check({name, ":a_ready_drain"}, a_ready, 0);
    if (!out_valid) return;
    for (int r = 0; r < ROWS; r++) begin
      stall = out_stall ? 3 : 0;
      for (int s = 0; s <= stall; s++) begin
        out_ready = (s == stall);
        start = start_in_drain && (r == 0);
        if (start) k_len = KW'(5);
        check_row(name, r);
        @(negedge clock);
      end
    end
    out_ready = 1'b0;
    start = 1'b0;
    check({name, ":done"}, done, 1);
    check({name, ":done16"}, done16, 1);
    check({name, ":idle"}, busy, 0);
    check({name, ":out_valid_end"}, out_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clock);
    check("rst:a_ready", a_ready, 0);
    check("rst:out_valid", out_valid, 0);
    check("rst:out_row", out_row, 0);
    check("rst:out_data", out_data == '0, 1);
    check("rst:busy", busy, 0);
    check("rst:done", done, 0);
    reset = 1'b0;
    @(negedge clock);

    fill_identity();
    run_op(4, 0, 1'b0, 1'b0, "ident");
    run_op(4, 1, 1'b1, 1'b1, "ident_stall");

    fill_const(256, 127, -128);
    run_op(256, 0, 1'b0, 1'b0, "k256");

    fill_const(4, 127, 127);
    run_op(4, 0, 1'b0, 1'b0, "sat16");

    run_op(0, 0, 1'b1, 1'b1, "k0");

    // Reset in the middle of LOAD, after some nonzero products have landed.
    @(negedge clock);
    fill_const(8, 3, 5);
    k_len = KW'(8);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int kk = 0; kk < 3; kk++) begin
      a_valid = 1'b1;
      drive_beat(kk, 1'b1);
      @(negedge clock);
    end
    a_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("midrst:busy", busy, 0);
    check("midrst:a_ready", a_ready, 0);
    check("midrst:out_valid", out_valid, 0);
    check("midrst:done", done, 0);
    check("midrst:out_data", out_data == '0, 1);
    check("midrst:out_data16", out_data16 == '0, 1);
    reset = 1'b0;
    @(negedge clock);
    fill_identity();
    run_op(4, 0, 1'b0, 1'b0, "post_rst");

    for (int t = 0; t < 6; t++) begin
      int k;
      k = $urandom_range(1, 24);
      fill_random(k);
      run_op(k, 2, 1'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", t));
    end

    @(negedge clock);
    check("final:done_pulse", done, 0);
    check("final:busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
